// File: rtl/conway_seq_ctrl.sv
// conway_seq_ctrl: valid/ready job sequencer that loads, steps and reads back the 8x8 serial Conway core.
// Optional macro CONWAY_SEQ_CONT_EN adds a 'cont' input that re-steps the result already held in the core.
module conway_seq_ctrl #(
  parameter int unsigned STEPS_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [63:0]        in_board,
  input  logic [STEPS_W-1:0] in_steps,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [63:0]        out_board,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef CONWAY_SEQ_CONT_EN
  input  logic               cont,
`endif
  output logic               busy,
  output logic [1:0]         core_mode,
  output logic               core_din,
  input  logic               core_dout
);

  localparam int unsigned BOARD_W = 64;
  localparam int unsigned BIT_W   = 6;

  localparam logic [BIT_W-1:0] BIT_LAST   = '1;
  localparam logic [1:0]       MODE_HOLD  = 2'b00;
  localparam logic [1:0]       MODE_SHIFT = 2'b01;
  localparam logic [1:0]       MODE_STEP  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_READ,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BOARD_W-2:0] shreg;
  logic [BOARD_W-1:0] out_shreg;
  logic [BIT_W-1:0]   bitcnt;
  logic [STEPS_W-1:0] stepcnt;
  logic [STEPS_W-1:0] steps_lat;
  logic               din_q;

  logic               accept;
  logic               bit_last;
  logic               step_last;
  logic               cont_go;

  logic [1:0]         mode_nxt;
  logic               busy_nxt;
  logic               in_ready_nxt;
  logic               out_valid_nxt;

`ifdef CONWAY_SEQ_CONT_EN
  assign cont_go = cont;
`else
  assign cont_go = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign bit_last  = (bitcnt == BIT_LAST);
  assign step_last = (stepcnt == STEPS_W'(1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (bit_last) state_nxt = (stepcnt != '0) ? S_STEP : S_READ;
      end
      S_STEP: begin
        if (step_last) state_nxt = S_READ;
      end
      S_READ: begin
        if (bit_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (cont_go) state_nxt = (steps_lat != '0) ? S_STEP : S_READ;
          else         state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output lands in a flop aligned with its state.
  always_comb begin
    mode_nxt      = MODE_HOLD;
    busy_nxt      = 1'b1;
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    case (state_nxt)
      S_IDLE: begin
        busy_nxt     = 1'b0;
        in_ready_nxt = 1'b1;
      end
      S_LOAD:  mode_nxt = MODE_SHIFT;
      S_STEP:  mode_nxt = MODE_STEP;
      S_READ:  mode_nxt = MODE_SHIFT;
      S_DONE:  out_valid_nxt = 1'b1;
      default: mode_nxt = MODE_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_mode <= MODE_HOLD;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      core_mode <= mode_nxt;
      busy      <= busy_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Datapath: bit 0 of the board goes straight to din_q, the remaining 63 bits queue behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      out_shreg <= '0;
      bitcnt    <= '0;
      stepcnt   <= '0;
      steps_lat <= '0;
      din_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg     <= in_board[BOARD_W-1:1];
            din_q     <= in_board[0];
            stepcnt   <= in_steps;
            steps_lat <= in_steps;
            bitcnt    <= '0;
          end
        end
        S_LOAD: begin
          shreg  <= {1'b0, shreg[BOARD_W-2:1]};
          din_q  <= bit_last ? 1'b0 : shreg[0];
          bitcnt <= bitcnt + BIT_W'(1);
        end
        S_STEP: begin
          stepcnt <= stepcnt - STEPS_W'(1);
        end
        S_READ: begin
          out_shreg[bitcnt] <= core_dout;
          bitcnt            <= bitcnt + BIT_W'(1);
        end
        S_DONE: begin
          if (out_ready && cont_go) stepcnt <= steps_lat;
        end
        default: begin
          bitcnt <= '0;
        end
      endcase
    end
  end

  // Readback recirculates core_dout so the core keeps its board after the result is read.
  assign core_din  = (state == S_READ) ? core_dout : din_q;
  assign out_board = out_shreg;

endmodule
